led_data_sel: RTL and testbench
===============================

# led_data_sel

Display-source selector that produces the 32-bit word consumed by the seven-segment `show` driver. It latches the CPU's display-syscall value and the three run-time counters (total, branch, jump). It cycles among these four sources on a debounced pushbutton and presents the chosen one as a registered `leddata` word. It sits between `MIPS_CPU` and `show`, replacing the fixed constant currently driven into the display.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: number of consecutive stable samples required before the button level is accepted (10 ms at 100 MHz).

Ports:
- `clk` in 1: system clock; all state is on its rising edge.
- `clr` in 1: reset, asynchronous and active-low (`clr`=0 resets).
- `syscall_valid` in 1: one-cycle pulse when the CPU executes the display syscall.
- `syscall_data` in 32: value to display, sampled when `syscall_valid`=1.
- `count_all` in 32: total instruction count from the CPU.
- `count_branch` in 32: taken-branch count.
- `count_jmp` in 32: jump count.
- `btn_mode` in 1: raw, asynchronous, bouncing pushbutton; active-high.
- `leddata` out 32: word to the `show` driver.
- `mode` out 2: current source; 0=SYS, 1=ALL, 2=BR, 3=JMP.

## Operation
- **Button path**
  - `btn_mode` passes through a 2-flop synchronizer to give `btn_s`.
  - The debounce counter is `$clog2(DEBOUNCE_CYCLES+1)` bits wide. It resets to 0 whenever `btn_s` equals the debounced level `btn_d`, and increments otherwise.
  - When the counter reaches `DEBOUNCE_CYCLES`, `btn_d` takes `btn_s` and the counter clears.
  - A rising edge on `btn_d` produces a one-cycle `step`. A falling edge produces nothing.
- **Mode FSM**: four states, SYS→ALL→BR→JMP→SYS. It advances only on `step` and wraps from 3 to 0.
- **Syscall register**: `sys_reg` loads `syscall_data` when `syscall_valid`=1 and holds otherwise. Back-to-back pulses each load; the last one wins.
- **Lamp test**
  - Flag `lamp` is set at reset.
  - It clears on the first `syscall_valid` or the first `step`, whichever comes first.
  - While `lamp`=1, `leddata` = 32'h87654321.
- **Output**: `leddata` is registered. Its next value is:
  - SYS: `sys_reg`
  - ALL: `count_all`
  - BR: `count_branch`
  - JMP: `count_jmp`
  - or the lamp pattern, when `lamp`=1.
- **Simultaneous `syscall_valid` and `step`**: both take effect in the same edge. If the new mode is SYS, `leddata` shows the newly latched value.
- **Reset values** (while `clr`=0): `leddata`=32'h87654321, `mode`=0, `sys_reg`=0, `lamp`=1, synchronizer flops=0, `btn_d`=0, debounce counter=0.
- **Reset mid-operation**: a debounce in progress is discarded. A button held through reset release is debounced afresh and produces exactly one `step` once accepted.

## Timing
- **Syscall to display**: `syscall_valid` sampled at edge E loads `sys_reg` at E. `leddata` updates at E+1 (in SYS mode).
- **Button to mode**: with D=`DEBOUNCE_CYCLES`, let edge R be the first edge that samples `btn_mode`=1 with the input stable afterwards. Then `btn_d` rises at R+2+D, `mode` changes at R+3+D, and `leddata` changes at R+4+D.
- **Bounce rejection**: any `btn_s` return to `btn_d` before D clears the count. Glitches shorter than D cycles never produce a `step`.
- **Counters**: counter inputs are sampled every cycle. In ALL/BR/JMP modes, `leddata` tracks its counter with 1-cycle latency.
- The module has no handshake back to the CPU and never stalls it.

## Configuration
- Macro: `LEDSEL_SNAPSHOT_EN`.
- **Defined**
  - On each `step`, the counter selected by the new mode is captured into a 32-bit snapshot register in the same edge as the `mode` update.
  - In ALL/BR/JMP, `leddata` shows the snapshot and stays static until the next `step`.
  - The snapshot resets to 0.
- **Undefined**: no snapshot register; counters are displayed live as described above.
- SYS mode and the lamp test behave identically in both builds.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4.
- **Reset**: hold `clr`=0, release, idle 20 cycles → `leddata`=32'h87654321, `mode`=0 throughout.
- **Syscall load**: pulse `syscall_valid` with `syscall_data`=32'hDEADBEEF at edge E → `leddata`=32'hDEADBEEF from E+1. Apply `syscall_data`=32'h1 without a pulse → no change.
- **Bounce rejection**: toggle `btn_mode` 1/0 every 2 cycles for 20 cycles, then hold 1 → exactly one `step`. `mode` goes 0→1 at R+7, where R is the first edge of the final stable 1. With `count_all`=32'd1234, `leddata`=32'd1234 at R+8.
- **Wrap-around**: four clean presses, with `count_branch`=7 and `count_jmp`=9 → `mode` sequence 1,2,3,0. `leddata` sequence `count_all`, 7, 9, `sys_reg`.
- **Simultaneous events**: in mode 3, `step` and `syscall_valid`(32'hCAFE0001) in the same edge → `mode`=0 and `leddata`=32'hCAFE0001 one edge later.
- **Reset mid-debounce**: assert `clr`=0 two cycles into a press with the button held, then release → no `step` before 6 cycles after release. Exactly one `step` afterwards. Under `LEDSEL_SNAPSHOT_EN`, with `count_all` incrementing in mode 1, `leddata` stays at the captured value.

Source files
------------

// File: rtl/led_data_sel_if.sv
// CPU-to-display bundle for led_data_sel: syscall value, run-time counters in,
// selected display word and current source out.
interface led_data_sel_if;
  logic        syscall_valid;
  logic [31:0] syscall_data;
  logic [31:0] count_all;
  logic [31:0] count_branch;
  logic [31:0] count_jmp;
  logic [31:0] leddata;
  logic [1:0]  mode;

  modport master (
    output syscall_valid, syscall_data, count_all, count_branch, count_jmp,
    input  leddata, mode
  );

  modport slave (
    input  syscall_valid, syscall_data, count_all, count_branch, count_jmp,
    output leddata, mode
  );
endinterface

// File: rtl/led_data_sel.sv
// Display-source selector: debounced button cycles SYS/ALL/BR/JMP into a registered leddata word.
// Optional build macro LEDSEL_SNAPSHOT_EN freezes counter sources at each mode step.
module led_data_sel #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           btn_mode,
  led_data_sel_if.slave  bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [31:0] LAMP_PATTERN = 32'h87654321;

  typedef enum logic [1:0] {
    SYS = 2'd0,
    ALL = 2'd1,
    BR  = 2'd2,
    JMP = 2'd3
  } mode_e;

  logic          sync1_q, btn_s_q;
  logic          btn_d_q, btn_d_d;
  logic          btn_d_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  mode_e         mode_q, mode_d;
  logic [31:0]   sys_reg_q, sys_reg_d;
  logic          lamp_q, lamp_d;
  logic [31:0]   leddata_q, leddata_d;
  logic          step;
`ifdef LEDSEL_SNAPSHOT_EN
  logic [31:0]   snap_q, snap_d;
  logic [31:0]   snap_src;
`endif

  // Counter runs only while the synchronized level disagrees with the accepted one.
  always_comb begin
    cnt_d   = cnt_q;
    btn_d_d = btn_d_q;
    if (btn_s_q == btn_d_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      btn_d_d = btn_s_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign step = btn_d_q & ~btn_d_prev_q;

  always_comb begin
    mode_d = mode_q;
    if (step) begin
      case (mode_q)
        SYS:     mode_d = ALL;
        ALL:     mode_d = BR;
        BR:      mode_d = JMP;
        default: mode_d = SYS;
      endcase
    end
  end

  always_comb begin
    sys_reg_d = bus.syscall_valid ? bus.syscall_data : sys_reg_q;
    lamp_d    = lamp_q & ~(step | bus.syscall_valid);
  end

`ifdef LEDSEL_SNAPSHOT_EN
  // Snapshot follows the mode being entered, so it lands in the same edge as mode_q.
  always_comb begin
    snap_src = '0;
    case (mode_d)
      ALL:     snap_src = bus.count_all;
      BR:      snap_src = bus.count_branch;
      JMP:     snap_src = bus.count_jmp;
      default: snap_src = sys_reg_q;
    endcase
    snap_d = step ? snap_src : snap_q;
  end
`endif

  always_comb begin
    leddata_d = LAMP_PATTERN;
    if (!lamp_q) begin
      case (mode_q)
        SYS:     leddata_d = sys_reg_q;
`ifdef LEDSEL_SNAPSHOT_EN
        default: leddata_d = snap_q;
`else
        ALL:     leddata_d = bus.count_all;
        BR:      leddata_d = bus.count_branch;
        default: leddata_d = bus.count_jmp;
`endif
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1_q      <= 1'b0;
      btn_s_q      <= 1'b0;
      btn_d_q      <= 1'b0;
      btn_d_prev_q <= 1'b0;
      cnt_q        <= '0;
      mode_q       <= SYS;
      sys_reg_q    <= '0;
      lamp_q       <= 1'b1;
      leddata_q    <= LAMP_PATTERN;
`ifdef LEDSEL_SNAPSHOT_EN
      snap_q       <= '0;
`endif
    end else begin
      sync1_q      <= btn_mode;
      btn_s_q      <= sync1_q;
      btn_d_q      <= btn_d_d;
      btn_d_prev_q <= btn_d_q;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      sys_reg_q    <= sys_reg_d;
      lamp_q       <= lamp_d;
      leddata_q    <= leddata_d;
`ifdef LEDSEL_SNAPSHOT_EN
      snap_q       <= snap_d;
`endif
    end
  end

  assign bus.leddata = leddata_q;
  assign bus.mode    = mode_q;
endmodule

// File: tb/tb_led_data_sel.sv
// Self-checking bench for led_data_sel (DEBOUNCE_CYCLES=4): directed literal checks
// plus randomized stimulus compared every cycle against a behavioural model.
module tb_led_data_sel;
  localparam int D = 4;
  localparam logic [31:0] LAMP = 32'h87654321;

  logic clk;
  logic clr;
  logic btn_mode;
  int   checks = 0;
  int   errors = 0;

  led_data_sel_if bus ();

  led_data_sel #(.DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .clr      (clr),
    .btn_mode (btn_mode),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: button level accepted after D+1 consecutive disagreeing
  // synchronized samples; a rise of the accepted level steps the mode one edge later.
  logic        m_sync [2];
  logic        m_bd, m_rise, m_lamp, m_step, m_bs;
  int          m_run;
  int          m_mode;
  logic [31:0] m_sys, m_led, m_snap;

  function automatic logic [31:0] counter_of(int m);
    case (m)
      1:       return bus.count_all;
      2:       return bus.count_branch;
      3:       return bus.count_jmp;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_sync[0] = 1'b0; m_sync[1] = 1'b0;
      m_bd = 1'b0; m_rise = 1'b0; m_run = 0;
      m_lamp = 1'b1; m_mode = 0; m_sys = 32'h0; m_snap = 32'h0;
      m_led = LAMP;
    end else begin
      m_step = m_rise;
      if (m_lamp)           m_led = LAMP;
      else if (m_mode == 0) m_led = m_sys;
`ifdef LEDSEL_SNAPSHOT_EN
      else                  m_led = m_snap;
`else
      else                  m_led = counter_of(m_mode);
`endif
      if (bus.syscall_valid) m_sys = bus.syscall_data;
      if (m_step) begin
        m_mode = (m_mode + 1) % 4;
        m_snap = counter_of(m_mode);
      end
      if (m_step || bus.syscall_valid) m_lamp = 1'b0;
      m_bs   = m_sync[1];
      m_rise = 1'b0;
      if (m_bs != m_bd) begin
        m_run++;
        if (m_run == D + 1) begin
          m_bd   = m_bs;
          m_run  = 0;
          m_rise = m_bs;
        end
      end else begin
        m_run = 0;
      end
      m_sync[1] = m_sync[0];
      m_sync[0] = btn_mode;
    end
  end

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (bus.leddata !== m_led) begin
        errors++;
        $display("FAIL model_leddata t=%0t: got %h expected %h", $time, bus.leddata, m_led);
      end
      checks++;
      if (bus.mode !== 2'(m_mode)) begin
        errors++;
        $display("FAIL model_mode t=%0t: got %0d expected %0d", $time, bus.mode, m_mode);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end else begin
      $display("ok   %s = %h", nm, got);
    end
  endtask

  task automatic press();
    btn_mode = 1'b1;
    tick(12);
    btn_mode = 1'b0;
    tick(12);
  endtask

  int run_left;

  initial begin
    btn_mode = 1'b0;
    bus.syscall_valid = 1'b0;
    bus.syscall_data  = 32'h0;
    bus.count_all     = 32'h0;
    bus.count_branch  = 32'h0;
    bus.count_jmp     = 32'h0;
    clr = 1'b1;
    #1 clr = 1'b0;
    chk_en = 1'b1;
    tick(3);
    clr = 1'b1;

    // Reset / lamp test
    tick(20);
    @(negedge clk);
    chk("reset_leddata", bus.leddata, LAMP);
    chk("reset_mode", 32'(bus.mode), 32'd0);

    // Syscall load
    bus.syscall_data  = 32'hDEADBEEF;
    bus.syscall_valid = 1'b1;
    tick(1);
    bus.syscall_valid = 1'b0;
    @(negedge clk);
    chk("syscall_E_still_lamp", bus.leddata, LAMP);
    tick(1);
    @(negedge clk);
    chk("syscall_E1_leddata", bus.leddata, 32'hDEADBEEF);
    bus.syscall_data = 32'h1;
    tick(3);
    @(negedge clk);
    chk("syscall_no_pulse_hold", bus.leddata, 32'hDEADBEEF);

    // Bounce rejection then a stable press
    bus.count_all    = 32'd1234;
    bus.count_branch = 32'd7;
    bus.count_jmp    = 32'd9;
    for (int i = 0; i < 10; i++) begin
      btn_mode = (i % 2 == 0);
      tick(2);
    end
    btn_mode = 1'b1;
    tick(7);
    @(negedge clk);
    chk("bounce_mode_R6", 32'(bus.mode), 32'd0);
    tick(1);
    @(negedge clk);
    chk("bounce_mode_R7", 32'(bus.mode), 32'd1);
    tick(1);
    @(negedge clk);
    chk("bounce_leddata_R8", bus.leddata, 32'd1234);
    tick(4);
    btn_mode = 1'b0;
    tick(12);

    // Wrap-around
    press();
    @(negedge clk);
    chk("wrap_mode_br", 32'(bus.mode), 32'd2);
    chk("wrap_leddata_br", bus.leddata, 32'd7);
    press();
    @(negedge clk);
    chk("wrap_mode_jmp", 32'(bus.mode), 32'd3);
    chk("wrap_leddata_jmp", bus.leddata, 32'd9);

    // Simultaneous step and syscall on edge R+7
    btn_mode = 1'b1;
    tick(7);
    bus.syscall_data  = 32'hCAFE0001;
    bus.syscall_valid = 1'b1;
    tick(1);
    bus.syscall_valid = 1'b0;
    @(negedge clk);
    chk("simul_mode", 32'(bus.mode), 32'd0);
    tick(1);
    @(negedge clk);
    chk("simul_leddata", bus.leddata, 32'hCAFE0001);
    tick(4);
    btn_mode = 1'b0;
    tick(12);
    press();
    @(negedge clk);
    chk("wrap_mode_all", 32'(bus.mode), 32'd1);
    chk("wrap_leddata_all", bus.leddata, 32'd1234);

    // Reset in the middle of a debounce, button held through release
    btn_mode = 1'b1;
    tick(2);
    clr = 1'b0;
    tick(3);
    clr = 1'b1;
    tick(6);
    @(negedge clk);
    chk("rst_mid_mode_R5", 32'(bus.mode), 32'd0);
    chk("rst_mid_lamp_R5", bus.leddata, LAMP);
    tick(2);
    @(negedge clk);
    chk("rst_mid_mode_R7", 32'(bus.mode), 32'd1);
    tick(1);
    @(negedge clk);
    chk("rst_mid_leddata", bus.leddata, 32'd1234);
    for (int i = 0; i < 8; i++) begin
      bus.count_all = bus.count_all + 32'd1;
      tick(1);
    end
    tick(2);
    @(negedge clk);
`ifdef LEDSEL_SNAPSHOT_EN
    chk("snapshot_static", bus.leddata, 32'd1234);
`else
    chk("live_counter", bus.leddata, 32'd1242);
`endif
    tick(20);
    @(negedge clk);
    chk("single_step_mode", 32'(bus.mode), 32'd1);
    btn_mode = 1'b0;
    tick(12);

    // Randomized traffic checked by the model every cycle
    run_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (run_left == 0) begin
        btn_mode = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 9);
      end
      run_left--;
      bus.syscall_valid = ($urandom_range(0, 7) == 0);
      bus.syscall_data  = $urandom;
      if ($urandom_range(0, 3) == 0) bus.count_all    = $urandom;
      if ($urandom_range(0, 3) == 0) bus.count_branch = $urandom;
      if ($urandom_range(0, 3) == 0) bus.count_jmp    = $urandom;
      if (c == 1500) clr = 1'b0;
      if (c == 1502) clr = 1'b1;
      tick(1);
    end
    bus.syscall_valid = 1'b0;
    tick(5);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
